// File: rtl/ir_sequencer_ctrl_if.sv
// Control bundle between the sequencer and the accumulator datapath.
// The slave side belongs to the sequencer. The master side belongs to the datapath or the bench.
interface ir_sequencer_ctrl_if #(
    parameter int OPW = 5
);
    logic [OPW-1:0] opCode;
    logic           MemReady;
    logic           AccZero;
    logic           IREnable;
    logic           PCWrite;
    logic           PCSrc;
    logic           MemRead;
    logic           MemWrite;
    logic           AccWrite;
    logic [1:0]     ALUOp;
    logic           Halted;
    logic           Fault;
    logic [2:0]     State;

    modport master (
        output opCode, MemReady, AccZero,
        input  IREnable, PCWrite, PCSrc, MemRead, MemWrite, AccWrite, ALUOp, Halted, Fault, State
    );

    modport slave (
        input  opCode, MemReady, AccZero,
        output IREnable, PCWrite, PCSrc, MemRead, MemWrite, AccWrite, ALUOp, Halted, Fault, State
    );
endinterface

// File: rtl/ir_sequencer_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the accumulator core, with a memory wait-timeout.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes halt the core with Fault instead of running as NOP.
module ir_sequencer_ctrl #(
    parameter int OPW      = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    ir_sequencer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [OPW-1:0] OP_LOAD  = OPW'(5'h01);
    localparam logic [OPW-1:0] OP_STORE = OPW'(5'h02);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(5'h03);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(5'h04);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(5'h05);
    localparam logic [OPW-1:0] OP_BEQZ  = OPW'(5'h06);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(5'h1F);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [7:0]     wait_q, wait_d;
    logic           fault_q, fault_d;

    logic [7:0]     wait_inc;
    logic           timeout;

    // The stalled cycle that would bring the count up to MAX_WAIT is the one that faults.
    assign wait_inc = wait_q + 8'd1;
    assign timeout  = (wait_inc == WAIT_LIMIT);

    always_ff @(posedge CLK) begin
        // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first; otherwise an unassigned branch infers a latch.
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        fault_d = fault_q;

        unique case (state_q)
            S_FETCH: begin
                if (bus.MemReady) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            S_DECODE: begin
                op_d = bus.opCode;
                if (bus.opCode == OP_HALT) begin
                    state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                end else if (bus.opCode > OP_BEQZ) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_STORE || op_q == OP_ADD || op_q == OP_SUB) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.MemReady) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.IREnable = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.AccWrite = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.Halted   = 1'b0;
        bus.Fault    = 1'b0;
        bus.State    = state_q;

        // Gating on Reset keeps the core quiet while reset is held, even before the first edge.
        if (!Reset) begin
            bus.Fault = fault_q;
            unique case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    if (bus.MemReady) begin
                        bus.IREnable = 1'b1;
                        bus.PCWrite  = 1'b1;
                    end
                end
                S_DECODE: ;
                S_EXEC: begin
                    if (op_q == OP_JUMP) begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = 1'b1;
                    end else if (op_q == OP_BEQZ) begin
                        bus.PCWrite = bus.AccZero;
                        bus.PCSrc   = 1'b1;
                    end
                end
                S_MEM: begin
                    if (op_q == OP_STORE) begin
                        bus.MemWrite = 1'b1;
                    end else begin
                        bus.MemRead  = 1'b1;
                    end
                end
                S_WB: begin
                    bus.AccWrite = 1'b1;
                    if (op_q == OP_ADD) begin
                        bus.ALUOp = 2'b01;
                    end else if (op_q == OP_SUB) begin
                        bus.ALUOp = 2'b10;
                    end
                end
                S_HALT:  bus.Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_sequencer_ctrl.sv
// Directed bench for ir_sequencer_ctrl: one linear stimulus sequence with hand-computed output vectors.
// Output vector layout: {IREnable,PCWrite,PCSrc,MemRead,MemWrite,AccWrite,ALUOp[1:0],Halted,Fault,State[2:0]}.
module tb_ir_sequencer_ctrl;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    ir_sequencer_ctrl_if #(.OPW(5)) bus ();

    ir_sequencer_ctrl #(
        .OPW      (5),
        .MAX_WAIT (15)
    ) dut (
        .CLK   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [12:0] obs;
    assign obs = {bus.IREnable, bus.PCWrite, bus.PCSrc, bus.MemRead, bus.MemWrite, bus.AccWrite,
                  bus.ALUOp, bus.Halted, bus.Fault, bus.State};

    function automatic logic [12:0] v(input logic ire, input logic pcw, input logic pcs,
                                      input logic mr, input logic mw, input logic aw,
                                      input logic [1:0] alu, input logic h, input logic f,
                                      input logic [2:0] st);
        return {ire, pcw, pcs, mr, mw, aw, alu, h, f, st};
    endfunction

    task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Let combinational outputs settle after the current inputs, compare, then advance one cycle.
    task automatic cyc(input string tag, input logic [12:0] e);
        #1;
        check(tag, obs, e);
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge. Strobes must already be quiet before that edge.
    task automatic do_reset(input string tag);
        Reset        = 1'b1;
        bus.MemReady = 1'b1;
        #1;
        check(tag, {obs[12:3], 3'b000}, 13'b0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        bus.opCode   = 5'h00;
        bus.MemReady = 1'b1;
        bus.AccZero  = 1'b0;

        // Reset held for two cycles.
        @(posedge clk);
        #1;
        cyc("reset_c1", v(0,0,0,0,0,0,2'b00,0,0,3'd0));
        check("reset_c2", obs, v(0,0,0,0,0,0,2'b00,0,0,3'd0));
        Reset = 1'b0;

        // First FETCH with memory stalled: only MemRead.
        bus.MemReady = 1'b0;
        cyc("fetch_idle", v(0,0,0,1,0,0,2'b00,0,0,3'd0));

        // ADD: five cycles through FETCH, DECODE, EXEC, MEM, WB.
        bus.MemReady = 1'b1;
        bus.opCode   = 5'h03;
        cyc("add_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("add_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("add_exec",   v(0,0,0,0,0,0,2'b00,0,0,3'd2));
        cyc("add_mem",    v(0,0,0,1,0,0,2'b00,0,0,3'd3));
        cyc("add_wb",     v(0,0,0,0,0,1,2'b01,0,0,3'd4));

        // STORE with three wait cycles in MEM: MemWrite is held for four cycles.
        bus.opCode = 5'h02;
        cyc("st_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("st_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("st_exec",   v(0,0,0,0,0,0,2'b00,0,0,3'd2));
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("st_mem_wait", v(0,0,0,0,1,0,2'b00,0,0,3'd3));
        bus.MemReady = 1'b1;
        cyc("st_mem_done", v(0,0,0,0,1,0,2'b00,0,0,3'd3));

        // SUB, back-to-back after the store completes.
        bus.opCode = 5'h04;
        cyc("sub_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("sub_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("sub_exec",   v(0,0,0,0,0,0,2'b00,0,0,3'd2));
        cyc("sub_mem",    v(0,0,0,1,0,0,2'b00,0,0,3'd3));
        cyc("sub_wb",     v(0,0,0,0,0,1,2'b10,0,0,3'd4));

        // LOAD writes back with ALU pass.
        bus.opCode = 5'h01;
        cyc("ld_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("ld_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("ld_exec",   v(0,0,0,0,0,0,2'b00,0,0,3'd2));
        cyc("ld_mem",    v(0,0,0,1,0,0,2'b00,0,0,3'd3));
        cyc("ld_wb",     v(0,0,0,0,0,1,2'b00,0,0,3'd4));

        // BEQZ taken and then not taken: three cycles each.
        bus.opCode  = 5'h06;
        bus.AccZero = 1'b1;
        cyc("beqz_t_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("beqz_t_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("beqz_t_exec",   v(0,1,1,0,0,0,2'b00,0,0,3'd2));
        bus.AccZero = 1'b0;
        cyc("beqz_n_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("beqz_n_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("beqz_n_exec",   v(0,0,1,0,0,0,2'b00,0,0,3'd2));

        // JUMP.
        bus.opCode = 5'h05;
        cyc("jmp_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("jmp_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("jmp_exec",   v(0,1,1,0,0,0,2'b00,0,0,3'd2));

        // Unlisted opcode 0A.
        bus.opCode = 5'h0A;
        cyc("ill_fetch",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("ill_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
`ifdef ILLEGAL_TRAP_EN
        cyc("ill_trap",   v(0,0,0,0,0,0,2'b00,1,1,3'd5));
        cyc("ill_sticky", v(0,0,0,0,0,0,2'b00,1,1,3'd5));
        do_reset("ill_rst");
`else
        cyc("ill_nop",    v(0,0,0,0,0,0,2'b00,0,0,3'd2));
`endif
        cyc("ill_after",  v(1,1,0,1,0,0,2'b00,0,0,3'd0));

        // HALT opcode: state 5 two cycles after FETCH, sticky, with no fault.
        bus.opCode = 5'h1F;
        cyc("halt_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("halt_c1",     v(0,0,0,0,0,0,2'b00,1,0,3'd5));
        cyc("halt_c2",     v(0,0,0,0,0,0,2'b00,1,0,3'd5));
        do_reset("halt_rst");

        // Fourteen stalls, then completion on the cycle that would otherwise time out.
        bus.opCode   = 5'h00;
        bus.MemReady = 1'b0;
        for (int i = 0; i < 14; i++) cyc("edge_wait", v(0,0,0,1,0,0,2'b00,0,0,3'd0));
        bus.MemReady = 1'b1;
        cyc("edge_done",   v(1,1,0,1,0,0,2'b00,0,0,3'd0));
        cyc("edge_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("edge_nop",    v(0,0,0,0,0,0,2'b00,0,0,3'd2));

        // Fifteen stalls in FETCH cause the timeout fault.
        bus.MemReady = 1'b0;
        for (int i = 0; i < 15; i++) cyc("to_wait", v(0,0,0,1,0,0,2'b00,0,0,3'd0));
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) cyc("to_halt", v(0,0,0,0,0,0,2'b00,1,1,3'd5));
        do_reset("to_rst");
        cyc("to_cleared", v(1,1,0,1,0,0,2'b00,0,0,3'd0));

        // Reset in the middle of a stalled STORE.
        bus.opCode = 5'h02;
        cyc("mid_decode", v(0,0,0,0,0,0,2'b00,0,0,3'd1));
        cyc("mid_exec",   v(0,0,0,0,0,0,2'b00,0,0,3'd2));
        bus.MemReady = 1'b0;
        cyc("mid_mem",    v(0,0,0,0,1,0,2'b00,0,0,3'd3));
        do_reset("mid_rst");
        bus.MemReady = 1'b0;
        cyc("mid_after",  v(0,0,0,1,0,0,2'b00,0,0,3'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
